ledr_channel_endpoint: RTL and testbench

LEDR_CHANNEL_ENDPOINT -- requirements
Module: ledr_channel_endpoint

---
 rtl/ledr_channel_endpoint.sv | 126 ++++++++++++
 tb/tb_ledr_channel_endpoint.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ledr_channel_endpoint.sv
// LEDR (level-encoded dual-rail) channel endpoint: valid/ready source to LEDR tx rails, LEDR rx rails to a FWFT sink FIFO.
// Build macro LEDR_CHANNEL_SYNC_EN selects a two-flop synchronizer (S=2) instead of a single sampling register (S=1).
module ledr_channel_endpoint #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         src_data,
  input  logic                     src_valid,
  output logic                     src_ready,
  output logic [WIDTH-1:0]         tx_d,
  output logic [WIDTH-1:0]         tx_r,
  input  logic                     tx_ack,
  input  logic [WIDTH-1:0]         rx_d,
  input  logic [WIDTH-1:0]         rx_r,
  output logic                     rx_ack,
  output logic [WIDTH-1:0]         snk_data,
  output logic                     snk_valid,
  input  logic                     snk_ready,
  output logic [$clog2(DEPTH):0]   snk_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic             ack_s;
  logic [WIDTH-1:0] rxd_s;
  logic [WIDTH-1:0] rxr_s;

`ifdef LEDR_CHANNEL_SYNC_EN
  logic             ack_m;
  logic [WIDTH-1:0] rxd_m;
  logic [WIDTH-1:0] rxr_m;

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_m <= 1'b0;
      rxd_m <= '0;
      rxr_m <= '0;
      ack_s <= 1'b0;
      rxd_s <= '0;
      rxr_s <= '0;
    end else begin
      ack_m <= tx_ack;
      rxd_m <= rx_d;
      rxr_m <= rx_r;
      ack_s <= ack_m;
      rxd_s <= rxd_m;
      rxr_s <= rxr_m;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_s <= 1'b0;
      rxd_s <= '0;
      rxr_s <= '0;
    end else begin
      ack_s <= tx_ack;
      rxd_s <= rx_d;
      rxr_s <= rx_r;
    end
  end
`endif

  // Transmit side: a new token may go out once the receiver has acked the previous phase.
  logic tx_phase;
  logic src_fire;

  assign src_ready = (ack_s == tx_phase) && !rst;
  assign src_fire  = src_valid && src_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_d     <= '0;
      tx_r     <= '0;
      tx_phase <= 1'b0;
    end else if (src_fire) begin
      tx_d     <= src_data;
      tx_r     <= src_data ^ {WIDTH{~tx_phase}};
      tx_phase <= ~tx_phase;
    end
  end

  // Receive side: a token is complete only when every bit has reached the expected phase.
  logic [WIDTH-1:0] rx_phase;
  logic             rx_complete;
  logic             full;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign rx_phase    = rxd_s ^ rxr_s;
  assign rx_complete = (rx_phase == {WIDTH{~rx_ack}});
  assign full        = (snk_count == FULL_CNT);
  assign push        = rx_complete && !full;
  assign snk_valid   = (snk_count != '0);
  assign pop         = snk_valid && snk_ready;
  assign snk_data    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ack    <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      snk_count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= rxd_s;
        wr_ptr      <= wr_ptr + 1'b1;
        rx_ack      <= ~rx_ack;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   snk_count <= snk_count + 1'b1;
        2'b01:   snk_count <= snk_count - 1'b1;
        default: snk_count <= snk_count;
      endcase
    end
  end

endmodule

// File: tb/tb_ledr_channel_endpoint.sv
// Directed bench: WIDTH=1 loopback endpoint plus a WIDTH=4/DEPTH=2 endpoint driven directly.
module tb_ledr_channel_endpoint;

`ifdef LEDR_CHANNEL_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // loopback instance
  logic       s1_data, s1_valid, s1_ready;
  logic       t1_d, t1_r, r1_ack;
  logic       k1_data, k1_valid, k1_ready;
  logic [1:0] k1_count;

  ledr_channel_endpoint #(.WIDTH(1), .DEPTH(2)) u1 (
    .clk(clk), .rst(rst),
    .src_data(s1_data), .src_valid(s1_valid), .src_ready(s1_ready),
    .tx_d(t1_d), .tx_r(t1_r), .tx_ack(r1_ack),
    .rx_d(t1_d), .rx_r(t1_r), .rx_ack(r1_ack),
    .snk_data(k1_data), .snk_valid(k1_valid), .snk_ready(k1_ready), .snk_count(k1_count)
  );

  // directly driven instance
  logic [3:0] s4_data;
  logic       s4_valid, s4_ready;
  logic [3:0] t4_d, t4_r;
  logic       a4;
  logic [3:0] rd4, rr4;
  logic       r4_ack;
  logic [3:0] k4_data;
  logic       k4_valid, k4_ready;
  logic [1:0] k4_count;

  ledr_channel_endpoint #(.WIDTH(4), .DEPTH(2)) u4 (
    .clk(clk), .rst(rst),
    .src_data(s4_data), .src_valid(s4_valid), .src_ready(s4_ready),
    .tx_d(t4_d), .tx_r(t4_r), .tx_ack(a4),
    .rx_d(rd4), .rx_r(rr4), .rx_ack(r4_ack),
    .snk_data(k4_data), .snk_valid(k4_valid), .snk_ready(k4_ready), .snk_count(k4_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic din;
    logic exp_d;
    logic exp_r;
  } lb_vec_t;

  lb_vec_t lb [4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic rx_tok(input logic [3:0] d, input logic ph);
    rd4 = d;
    rr4 = d ^ (ph ? 4'hF : 4'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] tgt;

    lb[0] = '{din: 1'b0, exp_d: 1'b0, exp_r: 1'b1};
    lb[1] = '{din: 1'b1, exp_d: 1'b1, exp_r: 1'b1};
    lb[2] = '{din: 1'b1, exp_d: 1'b1, exp_r: 1'b0};
    lb[3] = '{din: 1'b0, exp_d: 1'b0, exp_r: 1'b0};

    rst = 1'b1;
    s1_data = 1'b0; s1_valid = 1'b0; k1_ready = 1'b0;
    s4_data = 4'h0; s4_valid = 1'b0; a4 = 1'b0; rd4 = 4'h0; rr4 = 4'h0; k4_ready = 1'b0;
    step(); step();

    check("rst_src_ready1", {31'b0, s1_ready}, 0);
    check("rst_src_ready4", {31'b0, s4_ready}, 0);
    check("rst_tx_d4", {28'b0, t4_d}, 0);
    check("rst_tx_r4", {28'b0, t4_r}, 0);
    check("rst_rx_ack4", {31'b0, r4_ack}, 0);
    check("rst_snk_valid4", {31'b0, k4_valid}, 0);
    check("rst_snk_count4", {30'b0, k4_count}, 0);
    rst = 1'b0;
    step();
    check("post_rst_src_ready4", {31'b0, s4_ready}, 1);

    // empty FIFO ignores snk_ready
    k4_ready = 1'b1;
    step(); step();
    check("empty_pop_count", {30'b0, k4_count}, 0);
    k4_ready = 1'b0;

    // loopback: tx rails, push latency, data order
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!s1_ready && n < 50) begin step(); n++; end
      check("lb_src_ready", {31'b0, s1_ready}, 1);
      s1_data = lb[i].din;
      s1_valid = 1'b1;
      step();
      s1_valid = 1'b0;
      check("lb_tx_d", {31'b0, t1_d}, {31'b0, lb[i].exp_d});
      check("lb_tx_r", {31'b0, t1_r}, {31'b0, lb[i].exp_r});
      n = 0;
      while (!k1_valid && n < 50) begin step(); n++; end
      check("lb_latency", n, S + 1);
      check("lb_snk_data", {31'b0, k1_data}, {31'b0, lb[i].din});
      k1_ready = 1'b1;
      step();
      k1_ready = 1'b0;
      check("lb_count_after_pop", {30'b0, k1_count}, 0);
    end

    // FIFO full stalls the sender
    rx_tok(4'hA, 1'b1);
    repeat (S + 3) step();
    check("full_ack1", {31'b0, r4_ack}, 1);
    check("full_cnt1", {30'b0, k4_count}, 1);
    rx_tok(4'h5, 1'b0);
    repeat (S + 3) step();
    check("full_ack2", {31'b0, r4_ack}, 0);
    check("full_cnt2", {30'b0, k4_count}, 2);
    rx_tok(4'hC, 1'b1);
    repeat (6) step();
    check("full_ack_held", {31'b0, r4_ack}, 0);
    check("full_cnt_held", {30'b0, k4_count}, 2);
    check("full_head", {28'b0, k4_data}, 4'hA);
    k4_ready = 1'b1;
    step();
    k4_ready = 1'b0;
    check("full_pop_cnt", {30'b0, k4_count}, 1);
    check("full_pop_head", {28'b0, k4_data}, 4'h5);
    step();
    check("full_late_push_cnt", {30'b0, k4_count}, 2);
    check("full_third_ack", {31'b0, r4_ack}, 1);
    k4_ready = 1'b1;
    step();
    check("drain_head", {28'b0, k4_data}, 4'hC);
    check("drain_cnt1", {30'b0, k4_count}, 1);
    step();
    k4_ready = 1'b0;
    check("drain_cnt0", {30'b0, k4_count}, 0);

    // skewed arrival of token 0x6, one bit at a time
    tgt = 4'h6;
    for (int i = 0; i < 4; i++) begin
      rd4[i] = tgt[i];
      rr4[i] = tgt[i];
      repeat (S + 2) step();
      if (i < 3) begin
        check("skew_no_push", {30'b0, k4_count}, 0);
        check("skew_ack_held", {31'b0, r4_ack}, 1);
      end
    end
    check("skew_push", {30'b0, k4_count}, 1);
    check("skew_data", {28'b0, k4_data}, 4'h6);
    check("skew_ack", {31'b0, r4_ack}, 0);
    repeat (5) step();
    check("skew_single_push", {30'b0, k4_count}, 1);
    k4_ready = 1'b1;
    step();
    k4_ready = 1'b0;

    // tx stalls with tx_ack never toggled
    check("tx_idle_ready", {31'b0, s4_ready}, 1);
    s4_data = 4'h3;
    s4_valid = 1'b1;
    step();
    check("tx_sent_d", {28'b0, t4_d}, 4'h3);
    check("tx_sent_r", {28'b0, t4_r}, 4'hC);
    check("tx_busy", {31'b0, s4_ready}, 0);
    s4_data = 4'h9;
    repeat (5) step();
    check("tx_frozen_d", {28'b0, t4_d}, 4'h3);
    check("tx_frozen_r", {28'b0, t4_r}, 4'hC);
    check("tx_still_busy", {31'b0, s4_ready}, 0);
    s4_valid = 1'b0;
    a4 = 1'b1;
    repeat (S - 1) step();
    check("tx_ack_sync_pending", {31'b0, s4_ready}, 0);
    step();
    check("tx_ack_ready", {31'b0, s4_ready}, 1);

    // reset with a buffered entry and tx busy
    s4_data = 4'h5;
    s4_valid = 1'b1;
    step();
    s4_valid = 1'b0;
    check("pre_rst_tx_d", {28'b0, t4_d}, 4'h5);
    check("pre_rst_tx_r", {28'b0, t4_r}, 4'h5);
    rx_tok(4'hF, 1'b1);
    repeat (S + 3) step();
    check("pre_rst_cnt", {30'b0, k4_count}, 1);
    rst = 1'b1;
    rd4 = 4'h0; rr4 = 4'h0; a4 = 1'b0;
    step();
    check("mid_rst_src_ready", {31'b0, s4_ready}, 0);
    check("mid_rst_tx_d", {28'b0, t4_d}, 0);
    check("mid_rst_tx_r", {28'b0, t4_r}, 0);
    check("mid_rst_rx_ack", {31'b0, r4_ack}, 0);
    check("mid_rst_cnt", {30'b0, k4_count}, 0);
    check("mid_rst_valid", {31'b0, k4_valid}, 0);
    check("mid_rst_data", {28'b0, k4_data}, 0);
    rst = 1'b0;
    repeat (S + 2) step();
    check("after_rst_cnt", {30'b0, k4_count}, 0);
    check("after_rst_ready", {31'b0, s4_ready}, 1);
    s4_data = 4'h0;
    s4_valid = 1'b1;
    step();
    s4_valid = 1'b0;
    check("after_rst_tx_d", {28'b0, t4_d}, 4'h0);
    check("after_rst_tx_r", {28'b0, t4_r}, 4'hF);
    rx_tok(4'h0, 1'b1);
    repeat (S + 3) step();
    rx_tok(4'h1, 1'b0);
    repeat (S + 3) step();
    check("after_rst_rx_cnt", {30'b0, k4_count}, 2);
    check("after_rst_rx_ack", {31'b0, r4_ack}, 0);
    check("after_rst_head0", {28'b0, k4_data}, 4'h0);
    k4_ready = 1'b1;
    step();
    check("after_rst_head1", {28'b0, k4_data}, 4'h1);
    step();
    k4_ready = 1'b0;
    check("after_rst_drained", {30'b0, k4_count}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
